// File: rtl/mem_read_arbiter_rr.sv
`default_nettype none
// ============================================================================
//  Module      : mem_read_arbiter_rr
//  Description : N-master to single AXI read-port arbiter. One transaction is
//                outstanding at a time. Grants go round-robin or to the lowest
//                index. Beat accounting raises a sticky protocol-error flag.
//  Revision    : 1.0  initial release
// ============================================================================
module mem_read_arbiter_rr #(
  parameter int MASTERS    = 9,
  parameter int ADDR_WIDTH = 26,
  parameter int DATA_WIDTH = 32,
  parameter int RR_MODE    = 1
) (
  input  logic                          clk,
  input  logic                          rst,
  // master side
  input  logic [MASTERS-1:0]            m_arvalid,
  input  logic [MASTERS*ADDR_WIDTH-1:0] m_araddr,
  input  logic [MASTERS*4-1:0]          m_arlen,
  output logic [MASTERS-1:0]            m_arready,
  output logic [MASTERS-1:0]            m_rvalid,
  output logic                          m_rlast,
  output logic [DATA_WIDTH-1:0]         m_rdata,
  input  logic [MASTERS-1:0]            m_rready,
  // AXI read address channel
  output logic                          ARVALID,
  output logic [3:0]                    ARID,
  output logic [3:0]                    ARLEN,
  output logic [ADDR_WIDTH-1:0]         ARADDR,
  input  logic                          ARREADY,
  // AXI read data channel
  input  logic                          RVALID,
  input  logic                          RLAST,
  input  logic [3:0]                    RID,
  input  logic [DATA_WIDTH-1:0]         RDATA,
  output logic                          RREADY,
  // status
  output logic                          err
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_ADDR = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;

  logic [1:0]            state;
  logic [1:0]            state_next;
  logic [3:0]            grant;
  logic [3:0]            rr_ptr;
  logic [3:0]            beat_cnt;
  logic [3:0]            len_q;
  logic [ADDR_WIDTH-1:0] addr_q;

  logic [3:0]            base;
  logic [3:0]            hi_idx;
  logic [3:0]            lo_idx;
  logic                  hi_found;
  logic [3:0]            next_grant;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [3:0]            sel_len;
  logic                  rready_g;
  logic                  any_req;
  logic                  rid_match;
  logic                  beat_ok;
  logic                  stray;

  assign any_req   = |m_arvalid;
  assign rid_match = (RID == grant);
  // A matching beat is accepted only when the granted master is ready
  assign beat_ok   = (state == S_DATA) && RVALID && rid_match && rready_g;
  // Beats for any other ID are always drained so the bus cannot lock up
  assign stray     = (state == S_DATA) && RVALID && !rid_match;

  // Data and last are shared by all masters; m_rvalid selects the owner
  assign m_rdata = RDATA;
  assign m_rlast = RLAST;

  // Arbitration: lowest requester at/after base, else lowest requester overall
  always_comb begin
    base     = (RR_MODE != 0) ? rr_ptr : 4'd0;
    hi_found = 1'b0;
    hi_idx   = 4'd0;
    lo_idx   = 4'd0;
    for (int j = MASTERS - 1; j >= 0; j--) begin
      if (m_arvalid[j]) begin
        lo_idx = 4'(j);
        if (4'(j) >= base) begin
          hi_found = 1'b1;
          hi_idx   = 4'(j);
        end
      end
    end
    next_grant = hi_found ? hi_idx : lo_idx;
  end

  // Select request fields of the winner and the ready of the current owner
  always_comb begin
    sel_addr = '0;
    sel_len  = 4'd0;
    rready_g = 1'b0;
    for (int j = 0; j < MASTERS; j++) begin
      if (4'(j) == next_grant) begin
        sel_addr = m_araddr[j*ADDR_WIDTH +: ADDR_WIDTH];
        sel_len  = m_arlen[j*4 +: 4];
      end
      if (4'(j) == grant) begin
        rready_g = m_rready[j];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: if (any_req)           state_next = S_ADDR;
      S_ADDR: if (ARREADY)           state_next = S_DATA;
      S_DATA: if (beat_ok && RLAST)  state_next = S_IDLE;
      default:                       state_next = S_IDLE;
    endcase
  end

  // Output decode; everything handshake-related is forced low during reset
  always_comb begin
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    m_arready = '0;
    m_rvalid  = '0;
    ARID      = grant;
    ARADDR    = addr_q;
    ARLEN     = len_q;
    if (!rst) begin
      case (state)
        S_ADDR: begin
          ARVALID = 1'b1;
          for (int j = 0; j < MASTERS; j++) begin
            if (4'(j) == grant) m_arready[j] = ARREADY;
          end
        end
        S_DATA: begin
          RREADY = rid_match ? rready_g : 1'b1;
          for (int j = 0; j < MASTERS; j++) begin
            if (4'(j) == grant) m_rvalid[j] = RVALID && rid_match;
          end
        end
        default: ;
      endcase
    end
  end

  // Grant/request latch, beat counting, fairness pointer and error flag
  always_ff @(posedge clk) begin
    if (rst) begin
      grant    <= 4'd0;
      rr_ptr   <= 4'd0;
      beat_cnt <= 4'd0;
      len_q    <= 4'd0;
      addr_q   <= '0;
      err      <= 1'b0;
    end else begin
      if (state == S_IDLE && any_req) begin
        grant    <= next_grant;
        addr_q   <= sel_addr;
        len_q    <= sel_len;
        beat_cnt <= 4'd0;
      end
      if (beat_ok) begin
        beat_cnt <= beat_cnt + 4'd1;
        if (RLAST) begin
          // Early or late RLAST still completes the transaction
          if (beat_cnt != len_q) err <= 1'b1;
          if (RR_MODE != 0) begin
            rr_ptr <= (grant == 4'(MASTERS - 1)) ? 4'd0 : grant + 4'd1;
          end
        end else if (beat_cnt == len_q) begin
          // Final expected beat arrived without RLAST; keep waiting for it
          err <= 1'b1;
        end
      end
      if (stray) err <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_read_arbiter_rr.md
MEM_READ_ARBITER_RR -- requirements
Module: mem_read_arbiter_rr

Interface
REQ-001 Parameter MASTERS, default 9, number of read masters (2..16).
REQ-002 Parameter ADDR_WIDTH, default 26, byte-address width.
REQ-003 Parameter DATA_WIDTH, default 32, read-data width.
REQ-004 Parameter RR_MODE, default 1: 1 = round-robin grant; 0 = fixed priority, lowest index wins.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 m_arvalid  input  MASTERS  per-master read request.
REQ-008 m_araddr  input  MASTERS*ADDR_WIDTH  per-master address; master i occupies bits [i*ADDR_WIDTH +: ADDR_WIDTH].
REQ-009 m_arlen  input  MASTERS*4  per-master burst length minus one.
REQ-010 m_arready  output  MASTERS  per-master address accept.
REQ-011 m_rvalid  output  MASTERS  per-master read beat valid.
REQ-012 m_rlast  output  1  last beat, shared; qualified by m_rvalid.
REQ-013 m_rdata  output  DATA_WIDTH  read data, shared; qualified by m_rvalid.
REQ-014 m_rready  input  MASTERS  per-master beat accept.
REQ-015 ARVALID, ARID[3:0], ARLEN[3:0], ARADDR[ADDR_WIDTH-1:0]  output  AXI read address channel.
REQ-016 ARREADY  input  1  AXI address accept.
REQ-017 RVALID, RLAST, RID[3:0], RDATA[DATA_WIDTH-1:0]  input  AXI read data channel.
REQ-018 RREADY  output  1  AXI data accept.
REQ-019 err  output  1  sticky protocol-error flag.

Function
REQ-020 FSM states: IDLE, ADDR, DATA; exactly one transaction outstanding at any time.
REQ-021 IDLE: when any m_arvalid is high, grant g = first requester at or after rr_ptr, wrapping modulo MASTERS (RR_MODE=1), or lowest requesting index (RR_MODE=0); latch g, address and length; go to ADDR on the next edge.
REQ-022 IDLE with no requests: remain in IDLE, all outputs idle.
REQ-023 ADDR: ARVALID=1, ARID=g, ARADDR/ARLEN = latched values, stable until ARREADY.
REQ-024 ADDR: m_arready[g]=ARVALID&&ARREADY, combinational; on that handshake go to DATA; other m_arready bits stay 0.
REQ-025 DATA: m_rvalid[g]=RVALID&&(RID==g); RREADY=m_rready[g] when RID==g, otherwise 1 (stray beat drained).
REQ-026 m_rdata=RDATA and m_rlast=RLAST, pass-through with zero latency.
REQ-027 DATA: 4-bit beat counter starts at 0 and increments on each accepted beat with RID==g.
REQ-028 Accepted beat with RLAST=1 and RID==g: go to IDLE; in RR_MODE=1, rr_ptr=(g+1) mod MASTERS.
REQ-029 RLAST received with beat count != latched ARLEN: set err; still complete to IDLE.
REQ-030 Beat count reaches ARLEN with RLAST=0: set err; stay in DATA until RLAST.
REQ-031 Any beat with RID!=g accepted in DATA: set err; beat not forwarded.
REQ-032 err is sticky until rst.
REQ-033 Requests arriving during ADDR/DATA wait in IDLE arbitration; a grant never changes mid-transaction.
REQ-034 A master deasserting m_arvalid after grant does not cancel the transaction.
REQ-035 Back-to-back transactions: minimum one IDLE cycle between RLAST and the next ARVALID.

Reset
REQ-036 On rst: state=IDLE, rr_ptr=0, g=0, beat counter=0, err=0.
REQ-037 During rst: ARVALID=0, RREADY=0, m_arready=0, m_rvalid=0.
REQ-038 rst mid-ADDR or mid-DATA abandons the transaction with no completion beat to any master.

Verification
REQ-039 Single request: m_arvalid[3]=1, addr 0x100, len 3, ARREADY=1 -> ARID=3, ARADDR=0x100, ARLEN=3; 4 beats to master 3 only, last with m_rlast=1; IDLE afterwards; err=0.
REQ-040 Round-robin fairness: masters 0 and 5 continuously requesting, RR_MODE=1 -> grant order 0,5,0,5.
REQ-041 Fixed priority: masters 2 and 7 requesting, RR_MODE=0 -> 2 served repeatedly; 7 served only once 2 drops.
REQ-042 Backpressure: ARREADY low 5 cycles, then m_rready[g] toggling -> ARADDR/ARID stable while stalled, no beats lost, RREADY tracks m_rready[g].
REQ-043 Protocol errors: ARLEN=3 with RLAST on beat 2 -> err=1 and FSM returns to IDLE; separately, RID=6 while g=1 -> beat drained and err=1.
REQ-044 Reset mid-DATA after 2 of 4 beats -> next cycle IDLE, RREADY=0, err=0, rr_ptr=0.
